dff_piso_tx: RTL and testbench

Parallel-in, serial-out transmitter built from edge-triggered flip-flops: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a frame-start marker. It is the transmit end of the flip-flop serial link. It drives the serial side that a capture/shift-in register samples on its clock edge, and it sits between a parallel producer and that link.

---
 rtl/dff_piso_tx.sv | 157 +++++++++++++++
 tb/tb_dff_piso_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_piso_tx.sv
// -----------------------------------------------------------------------------
// dff_piso_tx
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out MSB-first, one bit per clock, with a
// frame-start marker on the first bit. A word can be accepted during the last
// bit of a frame, so the next frame follows with no idle cycle.
//
// Optional feature (macro DFF_PISO_TX_PARITY_EN):
//   When defined, an even-parity bit (^din) is captured at accept and sent
//   in one extra slot after the LSB. Frames are then WIDTH+1 bits long.
//   When undefined, frames are WIDTH bits and no parity register exists.
//
// Parameters:
//   WIDTH          data word width in bits (2 to 32)
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   din_i          parallel word, sampled only on an accepted load
//   load_valid_i   producer has a word on din_i
//   load_ready_o   a word can be accepted this cycle
//   sout_o         serial data bit (MSB first, parity last if enabled)
//   sout_valid_o   sout_o carries a frame bit this cycle
//   frame_start_o  first bit of a frame
//   busy_o         a frame is in progress
// -----------------------------------------------------------------------------
module dff_piso_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             frame_start_o,
    output logic             busy_o
);

`ifdef DFF_PISO_TX_PARITY_EN
    localparam int unsigned FrameLen = WIDTH + 1;
`else
    localparam int unsigned FrameLen = WIDTH;
`endif

    // Sized to hold WIDTH+1 so the parity slot index is representable.
    localparam int unsigned  CntW    = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [CntW-1:0]  cnt_q,   cnt_d;

`ifdef DFF_PISO_TX_PARITY_EN
    logic             par_q,   par_d;
    logic             parity_slot;
`endif

    logic in_shift;
    logic last_bit;
    logic accept;

    assign in_shift = (state_q == StShift);
    assign last_bit = in_shift && (cnt_q == LastCnt);

    // Ready depends only on state and reset so there is no valid->ready loop.
    assign load_ready_o = !reset_i && (!in_shift || last_bit);
    assign accept       = load_valid_i && load_ready_o;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef DFF_PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // Covers both a load from IDLE and a gapless reload at last_bit.
            state_d = StShift;
            sr_d    = din_i;
            cnt_d   = '0;
`ifdef DFF_PISO_TX_PARITY_EN
            par_d   = ^din_i;
`endif
        end else if (in_shift) begin
            if (last_bit) begin
                // Return to the same clean state that reset produces.
                state_d = StIdle;
                sr_d    = '0;
                cnt_d   = '0;
`ifdef DFF_PISO_TX_PARITY_EN
                par_d   = 1'b0;
`endif
            end else begin
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DFF_PISO_TX_PARITY_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    // The slot after the LSB carries parity instead of shifted-out data.
    assign parity_slot = in_shift && (cnt_q == CntW'(WIDTH));
`endif

    // -------------------------------------------------------------------------
    // Outputs: registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        sout_o        = 1'b0;
        sout_valid_o  = 1'b0;
        frame_start_o = 1'b0;
        busy_o        = 1'b0;
        if (in_shift) begin
`ifdef DFF_PISO_TX_PARITY_EN
            sout_o    = parity_slot ? par_q : sr_q[WIDTH-1];
`else
            sout_o    = sr_q[WIDTH-1];
`endif
            sout_valid_o  = 1'b1;
            frame_start_o = (cnt_q == '0);
            busy_o        = 1'b1;
        end
    end

endmodule

// File: tb/tb_dff_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_dff_piso_tx
//
// Self-checking bench for dff_piso_tx. A cycle-by-cycle vector table drives
// an 8-bit instance (reset, single frame, back-to-back, load while busy,
// asynchronous reset mid-frame, recovery). Hand-written sequences sweep the
// width extremes on 2-bit and 32-bit instances. Works with or without
// DFF_PISO_TX_PARITY_EN defined.
// -----------------------------------------------------------------------------
module tb_dff_piso_tx;

`ifdef DFF_PISO_TX_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif
    localparam int Fl8 = 8 + Par;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 8-bit instance
    logic [7:0] din8 = '0;
    logic       lv8  = 1'b0;
    logic       rdy8, s8, sv8, fs8, bz8;

    dff_piso_tx #(.WIDTH(8)) u_dut8 (
        .clk_i        (clk),
        .reset_i      (rst),
        .din_i        (din8),
        .load_valid_i (lv8),
        .load_ready_o (rdy8),
        .sout_o       (s8),
        .sout_valid_o (sv8),
        .frame_start_o(fs8),
        .busy_o       (bz8)
    );

    // 2-bit instance
    logic [1:0] din2 = '0;
    logic       lv2  = 1'b0;
    logic       rdy2, s2, sv2, fs2, bz2;

    dff_piso_tx #(.WIDTH(2)) u_dut2 (
        .clk_i        (clk),
        .reset_i      (rst),
        .din_i        (din2),
        .load_valid_i (lv2),
        .load_ready_o (rdy2),
        .sout_o       (s2),
        .sout_valid_o (sv2),
        .frame_start_o(fs2),
        .busy_o       (bz2)
    );

    // 32-bit instance
    logic [31:0] din32 = '0;
    logic        lv32  = 1'b0;
    logic        rdy32, s32, sv32, fs32, bz32;

    dff_piso_tx #(.WIDTH(32)) u_dut32 (
        .clk_i        (clk),
        .reset_i      (rst),
        .din_i        (din32),
        .load_valid_i (lv32),
        .load_ready_o (rdy32),
        .sout_o       (s32),
        .sout_valid_o (sv32),
        .frame_start_o(fs32),
        .busy_o       (bz32)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // One record per clock cycle: inputs applied after the rising edge,
    // outputs compared at the following falling edge.
    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] din;
        logic       s;
        logic       sv;
        logic       fs;
        logic       bz;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic r, input logic lv, input logic [7:0] d, input logic s,
                        input logic sv, input logic fs, input logic bz, input logic rdy);
        vec_t v;
        v.rst = r;  v.lv = lv; v.din = d;
        v.s   = s;  v.sv = sv; v.fs  = fs; v.bz = bz; v.rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic lv, input logic [7:0] d);
        push(1'b0, lv, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Expected cycles of a frame carrying w; nbits < Fl8 models a cut-short
    // frame. load_valid is high on every cycle if hold, else only at pulse_k.
    task automatic frame(input logic [7:0] w, input int nbits, input logic hold,
                         input logic [7:0] d, input int pulse_k);
        logic bit_v;
        for (int k = 0; k < nbits; k++) begin
            bit_v = (k < 8) ? w[7-k] : ^w;
            push(1'b0, hold || (k == pulse_k), d, bit_v, 1'b1, k == 0, 1'b1, k == Fl8 - 1);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst  = tbl[i].rst;
            lv8  = tbl[i].lv;
            din8 = tbl[i].din;
            @(negedge clk);
            check($sformatf("v%0d.sout", i),        {31'd0, s8},   {31'd0, tbl[i].s});
            check($sformatf("v%0d.sout_valid", i),  {31'd0, sv8},  {31'd0, tbl[i].sv});
            check($sformatf("v%0d.frame_start", i), {31'd0, fs8},  {31'd0, tbl[i].fs});
            check($sformatf("v%0d.busy", i),        {31'd0, bz8},  {31'd0, tbl[i].bz});
            check($sformatf("v%0d.load_ready", i),  {31'd0, rdy8}, {31'd0, tbl[i].rdy});
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] w;
    logic        eb;

    initial begin
        // Reset held: everything low, including ready, even with valid high.
        push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 8'h00);

        // Single frame 8'hA5, then idle with ready.
        idle(1'b1, 8'hA5);
        frame(8'hA5, Fl8, 1'b0, 8'h00, -1);
        idle(1'b0, 8'h00);

        // Back-to-back: 8'h3C held valid throughout the 8'hA5 frame.
        idle(1'b1, 8'hA5);
        frame(8'hA5, Fl8, 1'b1, 8'h3C, -1);
        frame(8'h3C, Fl8, 1'b0, 8'h00, -1);
        idle(1'b0, 8'h00);

        // Load pulse in cycle 3 of an 8'h00 frame is ignored.
        idle(1'b1, 8'h00);
        frame(8'h00, Fl8, 1'b0, 8'hFF, 2);
        idle(1'b0, 8'h00);
        idle(1'b0, 8'h00);

        // Back-to-back 8'hA5 -> 8'h07 (parity bits 0 and 1 when enabled).
        idle(1'b1, 8'hA5);
        frame(8'hA5, Fl8, 1'b1, 8'h07, -1);
        frame(8'h07, Fl8, 1'b0, 8'h00, -1);
        idle(1'b0, 8'h00);

        // Async reset after 3 bits of 8'hF0: applied between edges, so
        // outputs must already be clear at the following falling edge.
        idle(1'b1, 8'hF0);
        frame(8'hF0, 3, 1'b0, 8'h00, -1);
        push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 8'h00);
        idle(1'b0, 8'h00);
        idle(1'b1, 8'h81);
        frame(8'h81, Fl8, 1'b0, 8'h00, -1);
        idle(1'b0, 8'h00);

        run_table();

        // Width sweep, WIDTH=2: din=2'b10.
        w = 32'h0000_0002;
        @(posedge clk);
        #1;
        din2 = w[1:0];
        lv2  = 1'b1;
        @(negedge clk);
        check("w2.ready_idle", {31'd0, rdy2}, 32'd1);
        @(posedge clk);
        #1;
        lv2 = 1'b0;
        for (int k = 0; k < 2 + Par; k++) begin
            @(negedge clk);
            eb = (k < 2) ? w[1-k] : ^w[1:0];
            check($sformatf("w2.b%0d.sout", k),  {31'd0, s2},  {31'd0, eb});
            check($sformatf("w2.b%0d.valid", k), {31'd0, sv2}, 32'd1);
            check($sformatf("w2.b%0d.fs", k),    {31'd0, fs2}, (k == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("w2.end.valid", {31'd0, sv2},  32'd0);
        check("w2.end.ready", {31'd0, rdy2}, 32'd1);

        // Width sweep, WIDTH=32: din=32'h8000_0001.
        w = 32'h8000_0001;
        @(posedge clk);
        #1;
        din32 = w;
        lv32  = 1'b1;
        @(posedge clk);
        #1;
        lv32 = 1'b0;
        for (int k = 0; k < 32 + Par; k++) begin
            @(negedge clk);
            eb = (k < 32) ? w[31-k] : ^w;
            check($sformatf("w32.b%0d.sout", k),  {31'd0, s32},  {31'd0, eb});
            check($sformatf("w32.b%0d.valid", k), {31'd0, sv32}, 32'd1);
            check($sformatf("w32.b%0d.ready", k), {31'd0, rdy32},
                  (k == 31 + Par) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("w32.end.valid", {31'd0, sv32}, 32'd0);
        check("w32.end.busy",  {31'd0, bz32}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
